// File: rtl/multiplier_pkg.sv
// Shared constants for the streaming dot-product multiplier.
//   DEF_N     default number of element pairs per vector
//   DEF_W     default unsigned element width
//   idx_width width of the element index counter: clog2(n), never below 1
package multiplier_pkg;

    localparam int DEF_N = 3;
    localparam int DEF_W = 3;

    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/multiplier_if.sv
// Element-stream and result bus of the dot-product multiplier.
//   in_valid, number_vector1, number_vector2 : element pair from the source
//   out, out_valid, overflow                  : registered result to the sink
// Modport master is the stream source / result consumer; slave is the multiplier.
interface multiplier_if
    import multiplier_pkg::*;
#(
    parameter int W = DEF_W
);
    logic           in_valid;
    logic [W-1:0]   number_vector1;
    logic [W-1:0]   number_vector2;
    logic [2*W-1:0] out;
    logic           out_valid;
    logic           overflow;

    modport master (
        output in_valid, number_vector1, number_vector2,
        input  out, out_valid, overflow
    );

    modport slave (
        input  in_valid, number_vector1, number_vector2,
        output out, out_valid, overflow
    );
endinterface

// File: rtl/multiplier_mult_unit.sv
// Combinational unsigned W x W -> 2*W product.
//   a, b    : unsigned operands
//   product : full-width product, never truncated
module mult_unit #(
    parameter int W = 3
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product
);
    assign product = (2*W)'(a) * (2*W)'(b);
endmodule

// File: rtl/multiplier.sv
// Streaming unsigned dot product: accepts one element pair per valid cycle,
// index 0 first, and after the Nth pair registers the sum of products
// (mod 2^(2*W)) with a one-cycle out_valid pulse and a sticky-per-vector
// overflow flag.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : multiplier_if slave (pair stream in, result out)
module multiplier
    import multiplier_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic         clock,
    input  logic         reset_n,
    multiplier_if.slave  bus
);
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [IW-1:0]  idx;
    logic [2*W-1:0] acc;
    logic           carry_seen;
    logic [2*W-1:0] product;
    logic [2*W:0]   sum_ext;
    logic           last_pair;

    mult_unit #(.W(W)) u_mult (
        .a       (bus.number_vector1),
        .b       (bus.number_vector2),
        .product (product)
    );

    // One extra bit catches the carry out of the 2*W-bit accumulator.
    assign sum_ext   = {1'b0, acc} + {1'b0, product};
    assign last_pair = (idx == LAST_IDX);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idx           <= '0;
            acc           <= '0;
            carry_seen    <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.in_valid) begin
                if (last_pair) begin
                    bus.out       <= sum_ext[2*W-1:0];
                    bus.out_valid <= 1'b1;
                    bus.overflow  <= carry_seen | sum_ext[2*W];
                    acc           <= '0;
                    carry_seen    <= 1'b0;
                    idx           <= '0;
                end else begin
                    acc           <= sum_ext[2*W-1:0];
                    carry_seen    <= carry_seen | sum_ext[2*W];
                    idx           <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_multiplier.sv
module tb_multiplier;
    localparam int W = 3;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    multiplier_if #(.W(W)) bus3 ();
    multiplier_if #(.W(W)) bus1 ();

    multiplier #(.N(3), .W(W)) dut3 (.clock(clock), .reset_n(reset_n), .bus(bus3.slave));
    multiplier #(.N(1), .W(W)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1.slave));

    typedef struct {
        logic         rst_n;
        logic         valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           e_out;
        int           e_valid;
        int           e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state, one slot per DUT (0: N=3, 1: N=1).
    int m_n[2] = '{3, 1};
    int m_sum[2], m_cnt[2], m_out[2], m_v[2], m_ovf[2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input int a, input int b,
                       input int eo, input int ev, input int eov);
        vec_t t;
        t.rst_n = r; t.valid = v; t.a = W'(a); t.b = W'(b);
        t.e_out = eo; t.e_valid = ev; t.e_ovf = eov;
        vecs.push_back(t);
    endtask

    // Whole-vector view: a result appears once N pairs have been collected;
    // overflow means the true sum did not fit in 2*W bits.
    task automatic model_step(input int k, input logic r, input logic v, input int a, input int b);
        if (!r) begin
            m_sum[k] = 0; m_cnt[k] = 0; m_out[k] = 0; m_v[k] = 0; m_ovf[k] = 0;
        end else begin
            m_v[k] = 0;
            if (v) begin
                m_sum[k] += a * b;
                m_cnt[k]++;
                if (m_cnt[k] == m_n[k]) begin
                    m_out[k] = m_sum[k] % (1 << (2*W));
                    m_ovf[k] = (m_sum[k] >= (1 << (2*W))) ? 1 : 0;
                    m_v[k]   = 1;
                    m_sum[k] = 0;
                    m_cnt[k] = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v3, input int a3, input int b3,
                       input logic v1, input int a1, input int b1);
        reset_n             = r;
        bus3.in_valid       = v3;
        bus3.number_vector1 = W'(a3);
        bus3.number_vector2 = W'(b3);
        bus1.in_valid       = v1;
        bus1.number_vector1 = W'(a1);
        bus1.number_vector2 = W'(b1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus3.in_valid = 1'b0; bus3.number_vector1 = '0; bus3.number_vector2 = '0;
        bus1.in_valid = 1'b0; bus1.number_vector1 = '0; bus1.number_vector2 = '0;

        // N=3 directed table: {rst_n, valid, a, b, out, out_valid, overflow}
        add(0, 0, 0, 0,  0, 0, 0);
        add(1, 1, 3, 3,  0, 0, 0);
        add(1, 1, 2, 3,  0, 0, 0);
        add(1, 1, 3, 2, 21, 1, 0);
        add(1, 1, 1, 1, 21, 0, 0);
        add(1, 1, 1, 1, 21, 0, 0);
        add(1, 1, 1, 1,  3, 1, 0);
        add(1, 1, 7, 7,  3, 0, 0);
        add(1, 1, 7, 7,  3, 0, 0);
        add(1, 1, 7, 7, 19, 1, 1);
        add(1, 1, 1, 1, 19, 0, 1);
        add(1, 1, 1, 1, 19, 0, 1);
        add(1, 1, 1, 1,  3, 1, 0);
        add(1, 1, 3, 3,  3, 0, 0);
        add(1, 0, 5, 5,  3, 0, 0);
        add(1, 0, 6, 6,  3, 0, 0);
        add(1, 1, 2, 3,  3, 0, 0);
        add(1, 0, 7, 7,  3, 0, 0);
        add(1, 1, 3, 2, 21, 1, 0);
        add(1, 1, 3, 3, 21, 0, 0);
        add(1, 1, 2, 3, 21, 0, 0);
        add(0, 1, 7, 7,  0, 0, 0);
        add(1, 1, 1, 2,  0, 0, 0);
        add(1, 1, 1, 2,  0, 0, 0);
        add(1, 1, 1, 2,  6, 1, 0);
        add(1, 0, 0, 0,  6, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst_n, vecs[i].valid, int'(vecs[i].a), int'(vecs[i].b), 1'b0, 0, 0);
            check($sformatf("tbl%0d out", i),       int'(bus3.out),       vecs[i].e_out);
            check($sformatf("tbl%0d out_valid", i), int'(bus3.out_valid), vecs[i].e_valid);
            check($sformatf("tbl%0d overflow", i),  int'(bus3.overflow),  vecs[i].e_ovf);
        end

        // N=1: every accepted pair completes a vector.
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        check("n1 reset out", int'(bus1.out), 0);
        check("n1 reset valid", int'(bus1.out_valid), 0);
        cyc(1'b1, 1'b0, 0, 0, 1'b1, 5, 6);
        check("n1 first out", int'(bus1.out), 30);
        check("n1 first valid", int'(bus1.out_valid), 1);
        cyc(1'b1, 1'b0, 0, 0, 1'b1, 2, 2);
        check("n1 second out", int'(bus1.out), 4);
        check("n1 second valid", int'(bus1.out_valid), 1);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 7, 7);
        check("n1 idle out", int'(bus1.out), 4);
        check("n1 idle valid", int'(bus1.out_valid), 0);
        check("n1 idle overflow", int'(bus1.overflow), 0);

        // Randomized traffic on both instances against the vector-level model.
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        model_step(0, 1'b0, 1'b0, 0, 0);
        model_step(1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic r, v3, v1;
            int a3, b3, a1, b1;
            r  = ($urandom_range(0, 59) != 0);
            v3 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            a3 = $urandom_range(0, 7); b3 = $urandom_range(0, 7);
            a1 = $urandom_range(0, 7); b1 = $urandom_range(0, 7);
            cyc(r, v3, a3, b3, v1, a1, b1);
            model_step(0, r, v3, a3, b3);
            model_step(1, r, v1, a1, b1);
            check($sformatf("rnd%0d n3 out", i),      int'(bus3.out),       m_out[0]);
            check($sformatf("rnd%0d n3 valid", i),    int'(bus3.out_valid), m_v[0]);
            check($sformatf("rnd%0d n3 overflow", i), int'(bus3.overflow),  m_ovf[0]);
            check($sformatf("rnd%0d n1 out", i),      int'(bus1.out),       m_out[1]);
            check($sformatf("rnd%0d n1 valid", i),    int'(bus1.out_valid), m_v[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter N, default 3, number of element pairs per vector (N >= 1).
REQ-002 Parameter W, default 3, unsigned element width in bits (W >= 1).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-005 in_valid  input  1  element pair present this cycle.
REQ-006 number_vector1  input  W  unsigned element of vector A.
REQ-007 number_vector2  input  W  unsigned element of vector B.
REQ-008 out  output  2*W  registered dot product of last completed vector pair.
REQ-009 out_valid  output  1  one-cycle pulse marking a newly completed result on out.
REQ-010 overflow  output  1  registered; set when the completed result exceeded 2*W bits.

Function
REQ-011 Block SHALL compute the unsigned dot product sum(A[i]*B[i]), i = 0..N-1, elements streamed one pair per accepted cycle, index 0 first.
REQ-012 A pair SHALL be accepted on a rising edge with in_valid=1 and reset_n=1; in_valid=0 SHALL leave all state unchanged.
REQ-013 Each product SHALL be the full 2*W-bit unsigned product; accumulation SHALL be modulo 2^(2*W).
REQ-014 Internal element index SHALL count 0..N-1 and wrap to 0 after the Nth accepted pair.
REQ-015 On the edge accepting pair N-1: out <= (acc + product) mod 2^(2*W), out_valid <= 1, overflow <= any carry out of 2*W bits during that vector, acc <= 0, index <= 0.
REQ-016 Latency: result and out_valid SHALL be visible the cycle after the edge accepting the last pair; no further latency.
REQ-017 out_valid SHALL be 1 for exactly one cycle per completed vector and 0 otherwise.
REQ-018 out and overflow SHALL hold their values until the next completed vector.
REQ-019 Back-to-back vectors SHALL be supported with no bubble: the pair accepted the cycle after completion is index 0 of the next vector.
REQ-020 Idle gaps (in_valid=0) mid-vector SHALL not disturb the partial accumulation.
REQ-021 For N=1, every accepted pair SHALL produce a result and out_valid pulse.

Reset
REQ-022 With reset_n=0 at a rising edge: out=0, out_valid=0, overflow=0, accumulator=0, index=0.
REQ-023 Reset mid-vector SHALL discard the partial sum; the first pair accepted after reset is index 0.
REQ-024 Reset SHALL take priority over a simultaneous in_valid=1.

Structure
REQ-025 Package multiplier_pkg SHALL hold default N and W, and the index counter width constant/function (clog2 of N, minimum 1).
REQ-026 Sub-module mult_unit SHALL provide the combinational unsigned W x W -> 2*W product; accumulator, index counter and output registers reside in multiplier.
REQ-027 Design SHALL be synthesizable with no latches and no asynchronous logic.

Verification
REQ-028 N=3,W=3, pairs (3,3),(2,3),(3,2) with in_valid=1 on consecutive cycles -> out=21, out_valid=1 for one cycle after the third edge, overflow=0.
REQ-029 Same pairs followed immediately by (1,1),(1,1),(1,1) -> out=21 pulse then out=3 pulse three cycles later; out holds 21 in between.
REQ-030 Pairs (7,7)x3 -> out=19 (147 mod 64), overflow=1; following vector (1,1)x3 -> out=3, overflow=0.
REQ-031 Pairs (3,3), idle 2 cycles, (2,3), idle, (3,2) -> out=21 with out_valid only after last pair.
REQ-032 (3,3),(2,3), reset_n=0 one cycle, then (1,2),(1,2),(1,2) -> outputs 0 during/after reset, then out=6 with single out_valid pulse.
REQ-033 N=1,W=3, pairs (5,6),(2,2) -> out=30 then out=4, each with one out_valid pulse.
